ddr_frame_wr_master: RTL and testbench

//  Upstream AXI write master for DDR3 port 0 (aclk_0 domain). Packs a 16-bit pixel stream into
//  128-bit beats, buffers them in a FIFO, and writes one frame as INCR bursts starting at BASE_ADDR.
//  One burst is outstanding at a time. Pulses frame_done after the last write response.

---
 rtl/ddr_frame_wr_master.sv | 192 +++++++++++++++++++
 tb/tb_ddr_frame_wr_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_wr_master.sv
// ddr_frame_wr_master
//  AXI write master that streams one video frame into DDR. 16-bit pixels are
//  packed eight at a time into 128-bit beats, queued in a beat FIFO, and
//  written as INCR bursts starting at BASE_ADDR. Only one burst is in flight.
//  An AW request is raised only once the whole burst is already in the FIFO,
//  so the W channel never stalls on data once it starts.
// Ports
//  clk, rst            AXI clock, synchronous active-high reset
//  frame_start         pulse; starts a frame when idle
//  pix_valid/pix_data  pixel stream in; pix_ready accepts
//  busy, frame_done    frame in progress / one-cycle end-of-frame pulse
//  err_bresp           sticky non-OKAY write response, cleared by frame_start
//  axi_aw*, axi_w*, axi_b*  AXI write address, data and response channels
module ddr_frame_wr_master #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          FRAME_BEATS = 38400,
   parameter int          BURST_LEN   = 16,
   parameter logic [7:0]  AXI_ID      = 8'h00,
   parameter int          FIFO_DEPTH  = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         frame_start,
   input  logic         pix_valid,
   input  logic [15:0]  pix_data,
   output logic         pix_ready,
   output logic         busy,
   output logic         frame_done,
   output logic         err_bresp,
   output logic [31:0]  axi_awaddr,
   output logic [7:0]   axi_awid,
   output logic [7:0]   axi_awlen,
   output logic [2:0]   axi_awsize,
   output logic [1:0]   axi_awburst,
   output logic         axi_awlock,
   output logic         axi_awurgent,
   output logic         axi_awpoison,
   output logic         axi_awvalid,
   input  logic         axi_awready,
   output logic [127:0] axi_wdata,
   output logic [15:0]  axi_wstrb,
   output logic         axi_wlast,
   output logic         axi_wvalid,
   input  logic         axi_wready,
   input  logic [7:0]   axi_bid,
   input  logic [1:0]   axi_bresp,
   input  logic         axi_bvalid,
   output logic         axi_bready
);

   localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CW        = AW + 1;
   localparam logic [23:0] PIX_TOTAL = 24'(FRAME_BEATS * 8);

   typedef enum logic [2:0] {IDLE, WAIT, ADDR, DATA, RESP} state_t;
   state_t state;

   logic [23:0]   pix_cnt;
   logic [2:0]    pack_cnt;
   logic [111:0]  pack_buf;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_count;
   logic [127:0]  fifo_mem [FIFO_DEPTH];
   logic [20:0]   beats_rem;   // beats not yet covered by an issued AW
   logic [8:0]    blen;        // beats in the next burst
   logic [7:0]    wbeat;
   logic          start, fifo_full, pix_fire, push, pop;
   logic          unused_bid;

   assign axi_awid     = AXI_ID;
   assign axi_awsize   = 3'd4;
   assign axi_awburst  = 2'b01;
   assign axi_awlock   = 1'b0;
   assign axi_awurgent = 1'b0;
   assign axi_awpoison = 1'b0;
   assign axi_wstrb    = 16'hFFFF;
   assign unused_bid   = ^axi_bid;

   assign start     = (state == IDLE) & frame_start;
   assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
   // Only the pixel that completes a beat needs FIFO space.
   assign pix_ready = busy & (pix_cnt < PIX_TOTAL) & ~((pack_cnt == 3'd7) & fifo_full);
   assign pix_fire  = pix_valid & pix_ready;
   assign push      = pix_fire & (pack_cnt == 3'd7);
   assign pop       = axi_wvalid & axi_wready;
   assign axi_wdata = fifo_mem[rd_ptr];
   assign blen      = (beats_rem >= 21'(BURST_LEN)) ? 9'(BURST_LEN) : beats_rem[8:0];

   // Pixel packer: slots 0..6 are held in pack_buf, the 8th pixel goes
   // straight into the FIFO together with them.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt  <= '0;
         pack_cnt <= '0;
         pack_buf <= '0;
      end else if (start) begin
         pix_cnt  <= '0;
         pack_cnt <= '0;
      end else if (pix_fire) begin
         pix_cnt  <= pix_cnt + 24'd1;
         pack_cnt <= pack_cnt + 3'd1;
         if (pack_cnt != 3'd7) pack_buf[{pack_cnt, 4'd0} +: 16] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {pix_data, pack_buf};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         err_bresp   <= 1'b0;
         axi_awaddr  <= '0;
         axi_awlen   <= '0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_wlast   <= 1'b0;
         axi_bready  <= 1'b0;
         beats_rem   <= '0;
         wbeat       <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (frame_start) begin
               busy       <= 1'b1;
               err_bresp  <= 1'b0;
               beats_rem  <= 21'(FRAME_BEATS);
               axi_awaddr <= BASE_ADDR;
               state      <= WAIT;
            end
            WAIT: if (32'(fifo_count) >= 32'(blen)) begin
               axi_awlen   <= 8'(blen - 9'd1);
               axi_awvalid <= 1'b1;
               state       <= ADDR;
            end
            ADDR: if (axi_awready) begin
               axi_awvalid <= 1'b0;
               axi_wvalid  <= 1'b1;
               axi_wlast   <= (axi_awlen == 8'd0);
               wbeat       <= '0;
               beats_rem   <= beats_rem - (21'(axi_awlen) + 21'd1);
               // Next burst address; the current one has already been taken.
               axi_awaddr  <= axi_awaddr + ((32'(axi_awlen) + 32'd1) << 4);
               state       <= DATA;
            end
            DATA: if (axi_wready) begin
               if (axi_wlast) begin
                  axi_wvalid <= 1'b0;
                  axi_wlast  <= 1'b0;
                  axi_bready <= 1'b1;
                  state      <= RESP;
               end else begin
                  wbeat     <= wbeat + 8'd1;
                  axi_wlast <= ((wbeat + 8'd1) == axi_awlen);
               end
            end
            RESP: if (axi_bvalid) begin
               axi_bready <= 1'b0;
               if (axi_bresp != 2'b00) err_bresp <= 1'b1;
               if (beats_rem == '0) begin
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  state <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_frame_wr_master.sv
// Bench for ddr_frame_wr_master: drives pixel frames, acts as the AXI slave
// with an optional random stall pattern, and compares bursts, beat data and
// control pulses with a frame-level model (pixel list -> expected beats and
// burst plan computed arithmetically).
module tb_ddr_frame_wr_master;
   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          FB    = 68;
   localparam int          BL    = 16;
   localparam int          FD    = 64;
   localparam logic [7:0]  ID    = 8'h5A;
   localparam int          TOTAL = FB * 8;
   localparam int          NB    = (FB + BL - 1) / BL;

   logic         clk = 1'b0;
   logic         rst, frame_start, pix_valid, pix_ready, busy, frame_done, err_bresp;
   logic [15:0]  pix_data;
   logic [31:0]  axi_awaddr;
   logic [7:0]   axi_awid, axi_awlen, axi_bid;
   logic [2:0]   axi_awsize;
   logic [1:0]   axi_awburst, axi_bresp;
   logic         axi_awlock, axi_awurgent, axi_awpoison, axi_awvalid, axi_awready;
   logic [127:0] axi_wdata;
   logic [15:0]  axi_wstrb;
   logic         axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;

   always #5 clk = ~clk;

   ddr_frame_wr_master #(
      .BASE_ADDR(BASE), .FRAME_BEATS(FB), .BURST_LEN(BL), .AXI_ID(ID), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .busy(busy), .frame_done(frame_done), .err_bresp(err_bresp),
      .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
      .axi_awurgent(axi_awurgent), .axi_awpoison(axi_awpoison),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic [15:0]  pix_seq [TOTAL];
   logic [127:0] mem [FB];
   int           pix_idx, aw_idx, b_idx, b_pend, beat, err_burst, cur_len;
   logic [31:0]  cur_addr;
   bit           stall, aw_hold, pix_en, aw_done, last_b, done_seen, bv_clear, aw_wait, w_wait;
   logic [31:0]  p_awaddr;
   logic [7:0]   p_awlen;
   logic [127:0] p_wdata;
   logic         p_wlast;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit coin();
      return $urandom_range(1) == 1;
   endfunction

   function automatic logic [127:0] beat_of(input int i);
      logic [127:0] r;
      for (int p = 0; p < 8; p++) r[16*p +: 16] = pix_seq[8*i + p];
      return r;
   endfunction

   task automatic reset_model();
      pix_idx = 0; aw_idx = 0; b_idx = 0; b_pend = 0; beat = 0; cur_len = 0;
      cur_addr = BASE; aw_done = 0; last_b = 0; done_seen = 0; bv_clear = 0;
      aw_wait = 0; w_wait = 0;
      for (int i = 0; i < FB; i++) mem[i] = 'x;
   endtask

   task automatic new_frame(input bit rnd);
      for (int i = 0; i < TOTAL; i++) pix_seq[i] = rnd ? 16'($urandom) : 16'(i);
      reset_model();
   endtask

   // One clock of bench activity at the falling edge: check held/pulsed
   // outputs, pick new ready/valid values, then log the handshakes that the
   // next rising edge will complete.
   task automatic tick();
      int   idx, rem;
      logic exp_rdy;
      @(negedge clk);
      if (rst) begin
         axi_awready = 0; axi_wready = 0; axi_bvalid = 0; pix_valid = 0;
         b_pend = 0; bv_clear = 0; last_b = 0; aw_wait = 0; w_wait = 0; aw_done = 0;
      end else begin
         if (aw_wait) begin
            check("aw_hold_valid", 128'(axi_awvalid), 128'(1));
            check("aw_hold_addr", 128'(axi_awaddr), 128'(p_awaddr));
            check("aw_hold_len", 128'(axi_awlen), 128'(p_awlen));
         end
         if (w_wait) begin
            check("w_hold_valid", 128'(axi_wvalid), 128'(1));
            check("w_hold_data", axi_wdata, p_wdata);
            check("w_hold_last", 128'(axi_wlast), 128'(p_wlast));
         end
         check("frame_done", 128'(frame_done), 128'(last_b));
         if (frame_done) done_seen = 1;
         last_b = 0;
         check("aw_w_excl", 128'(axi_awvalid & axi_wvalid), 128'(0));
         if (busy && pix_idx >= TOTAL) check("pix_ready_end", 128'(pix_ready), 128'(0));
         if (aw_hold && busy) begin
            exp_rdy = (pix_idx < TOTAL) && !((pix_idx % 8 == 7) && (pix_idx / 8 >= FD));
            check("pix_ready_hold", 128'(pix_ready), 128'(exp_rdy));
         end
         axi_awready = !aw_hold && (!stall || coin());
         axi_wready  = !stall || coin();
         if (bv_clear) begin axi_bvalid = 0; bv_clear = 0; end
         if (!axi_bvalid && b_pend > 0 && (!stall || coin())) begin
            axi_bvalid = 1;
            axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            b_pend--;
         end
         pix_valid = pix_en && (pix_idx < TOTAL) && (!stall || coin());
         pix_data  = (pix_idx < TOTAL) ? pix_seq[pix_idx] : 16'($urandom);
         if (axi_wvalid && axi_wready) begin
            check("w_after_aw", 128'(aw_done), 128'(1));
            check("wlast", 128'(axi_wlast), 128'(beat == cur_len - 1));
            idx = int'((cur_addr - BASE) >> 4) + beat;
            check("w_in_frame", 128'(idx < FB), 128'(1));
            if (idx < FB) mem[idx] = axi_wdata;
            beat++;
            if (axi_wlast) begin b_pend++; aw_done = 0; end
         end
         if (axi_awvalid && axi_awready) begin
            rem     = FB - aw_idx * BL;
            cur_len = (rem < BL) ? rem : BL;
            check("aw_in_frame", 128'(aw_idx < NB), 128'(1));
            check("awaddr", 128'(axi_awaddr), 128'(BASE + 32'(aw_idx * BL * 16)));
            check("awlen", 128'(axi_awlen), 128'(cur_len - 1));
            cur_addr = axi_awaddr; beat = 0; aw_done = 1; aw_idx++;
         end
         if (axi_bvalid && axi_bready) begin
            last_b = (b_idx == NB - 1);
            b_idx++;
            bv_clear = 1;
         end
         if (pix_valid && pix_ready) pix_idx++;
         aw_wait = axi_awvalid && !axi_awready; p_awaddr = axi_awaddr; p_awlen = axi_awlen;
         w_wait  = axi_wvalid && !axi_wready;   p_wdata = axi_wdata;   p_wlast = axi_wlast;
      end
   endtask

   task automatic start_frame();
      frame_start = 1;
      tick();
      frame_start = 0;
      check("busy_start", 128'(busy), 128'(1));
   endtask

   task automatic finish_frame(input string tag);
      for (int c = 0; c < 20000 && !done_seen; c++) tick();
      check({tag, "_done"}, 128'(done_seen), 128'(1));
      check({tag, "_busy_end"}, 128'(busy), 128'(0));
      check({tag, "_bursts"}, 128'(aw_idx), 128'(NB));
      check({tag, "_bresps"}, 128'(b_idx), 128'(NB));
      for (int i = 0; i < FB; i++) check({tag, "_mem"}, mem[i], beat_of(i));
   endtask

   initial begin
      rst = 1; frame_start = 0; pix_valid = 0; pix_data = '0;
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0; axi_bid = ID;
      stall = 0; aw_hold = 0; pix_en = 1; err_burst = -1;
      new_frame(0);
      repeat (3) tick();
      check("rst_awvalid", 128'(axi_awvalid), 128'(0));
      check("rst_wvalid", 128'(axi_wvalid), 128'(0));
      check("rst_wlast", 128'(axi_wlast), 128'(0));
      check("rst_bready", 128'(axi_bready), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(frame_done), 128'(0));
      check("rst_err", 128'(err_bresp), 128'(0));
      check("rst_pix_ready", 128'(pix_ready), 128'(0));
      check("rst_awaddr", 128'(axi_awaddr), 128'(0));
      check("rst_awlen", 128'(axi_awlen), 128'(0));
      check("awid", 128'(axi_awid), 128'(ID));
      check("awsize", 128'(axi_awsize), 128'(4));
      check("awburst", 128'(axi_awburst), 128'(1));
      check("aw_misc", 128'({axi_awlock, axi_awurgent, axi_awpoison}), 128'(0));
      check("wstrb", 128'(axi_wstrb), 128'(16'hFFFF));
      rst = 0;
      tick();

      // Counting pixels, no backpressure; a second frame_start mid-frame is ignored.
      new_frame(0);
      start_frame();
      repeat (100) tick();
      frame_start = 1;
      tick();
      frame_start = 0;
      finish_frame("f1");
      check("first_beat", mem[0], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
      check("f1_err", 128'(err_bresp), 128'(0));

      // Random pixels with random stalls on every channel.
      stall = 1;
      new_frame(1);
      start_frame();
      finish_frame("f2");

      // AW held off: FIFO fills, then the stream resumes.
      stall = 0; aw_hold = 1;
      new_frame(1);
      start_frame();
      for (int c = 0; c < 3000 && pix_idx < FD * 8 + 7; c++) tick();
      check("hold_fill", 128'(pix_idx), 128'(FD * 8 + 7));
      repeat (20) tick();
      check("hold_stuck", 128'(pix_idx), 128'(FD * 8 + 7));
      aw_hold = 0;
      finish_frame("f3");

      // Error response on the first burst does not abort the frame.
      stall = 1; err_burst = 0;
      new_frame(1);
      start_frame();
      finish_frame("f4");
      check("err_sticky", 128'(err_bresp), 128'(1));

      // Next frame clears the error; reset it while in the data phase.
      err_burst = -1;
      new_frame(1);
      start_frame();
      check("err_cleared", 128'(err_bresp), 128'(0));
      for (int c = 0; c < 5000 && !axi_wvalid; c++) tick();
      check("reach_data", 128'(axi_wvalid), 128'(1));
      rst = 1;
      tick();
      check("mid_rst_awvalid", 128'(axi_awvalid), 128'(0));
      check("mid_rst_wvalid", 128'(axi_wvalid), 128'(0));
      check("mid_rst_bready", 128'(axi_bready), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      rst = 0;
      tick();

      // Fresh frame after the reset restarts at BASE.
      new_frame(1);
      start_frame();
      finish_frame("f6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
